irq_ctrl: RTL and testbench

- Interrupt sequencer for the 5-stage pipelined core. It synchronises external interrupt lines, latches them as pending, and picks the highest-priority enabled source.
- It takes the trap at a safe pipeline point. In that cycle it flushes IF/ID, ID/EX and EX/MEM and redirects the PC to a per-source vector.
- On mret it flushes the pipeline and redirects the PC back to the saved EPC.
- It sits beside the hazard-detection unit. Its flush_o is ORed into the pipeline flush and its redirect_o/redirect_pc into the PC-next mux, at higher priority than pc_incr.

---
 rtl/irq_ctrl_if.sv | 26 ++
 rtl/irq_ctrl.sv | 59 +++++
 tb/tb_irq_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: pipeline-side signal bundle for the interrupt sequencer
interface irq_ctrl_if #(parameter int NUM_SRC = 4);
  logic [NUM_SRC-1:0] irq_in;
  logic               en_we;
  logic [NUM_SRC-1:0] en_wdata;
  logic [31:0]        ex_pc;
  logic               ex_valid;
  logic               pc_src;
  logic               stall;
  logic               mret_mem;
  logic               flush_o;
  logic               redirect_o;
  logic [31:0]        redirect_pc;
  logic               in_handler;
  logic [3:0]         cause;
  logic [31:0]        epc;
  logic [NUM_SRC-1:0] en_mask;
  modport master (
    output irq_in, en_we, en_wdata, ex_pc, ex_valid, pc_src, stall, mret_mem,
    input  flush_o, redirect_o, redirect_pc, in_handler, cause, epc, en_mask
  );
  modport slave (
    input  irq_in, en_we, en_wdata, ex_pc, ex_valid, pc_src, stall, mret_mem,
    output flush_o, redirect_o, redirect_pc, in_handler, cause, epc, en_mask
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises irq lines, latches pending edges and sequences trap entry/mret redirects
module irq_ctrl #(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
  input logic        clk,
  input logic        rst,
  irq_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, HANDLER} state_t;
  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d, en_mask_q, elig, clr;
  logic [31:0]        epc_q;
  logic [3:0]         cause_q, sel;
  logic               take, mret;
  assign elig = pending_q & en_mask_q;
  // descending scan leaves the lowest eligible index in sel
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) sel = elig[i] ? 4'(i) : sel;
  end
  always_comb begin
    take    = (state_q == IDLE) && (|elig) && bus.ex_valid && !bus.pc_src && !bus.stall;
    mret    = (state_q == HANDLER) && bus.mret_mem;
    state_d = take ? HANDLER : mret ? IDLE : state_q;
  end
  // a fresh edge is ORed in after the take clear, so set wins
  assign clr       = take ? (NUM_SRC'(1) << sel) : '0;
  assign pending_d = (pending_q & ~clr) | (sync2_q & ~sync3_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
      en_mask_q <= '0;
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      sync1_q   <= bus.irq_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
      en_mask_q <= bus.en_we ? bus.en_wdata : en_mask_q;
      state_q   <= state_d;
      epc_q     <= take ? bus.ex_pc : epc_q;
      cause_q   <= take ? sel : cause_q;
    end
  end
  assign bus.flush_o     = take | mret;
  assign bus.redirect_o  = take | mret;
  assign bus.redirect_pc = take ? VECTOR_BASE + {26'b0, sel, 2'b00} : mret ? epc_q : '0;
  assign bus.in_handler  = (state_q == HANDLER);
  assign bus.cause       = cause_q;
  assign bus.epc         = epc_q;
  assign bus.en_mask     = en_mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus random stimulus checked against a cycle-level reference model
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  irq_ctrl_if #(.NUM_SRC(4)) bus ();
  irq_ctrl #(.NUM_SRC(4), .VECTOR_BASE(32'h0000_0100)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  m_pend, m_mask, m_cause;
  logic        m_hand;
  logic [31:0] m_epc;
  logic [3:0]  hist[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int first_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_cause = 0; m_hand = 0; m_epc = 0;
    hist = {4'h0, 4'h0, 4'h0, 4'h0};
  endtask
  task automatic step();
    logic       tk, mr;
    logic [3:0] el, rise;
    int         s;
    #2;
    el = m_pend & m_mask;
    tk = !m_hand && el != 0 && bus.ex_valid && !bus.pc_src && !bus.stall;
    mr = m_hand && bus.mret_mem;
    s  = first_idx(el);
    chk("flush_o", bus.flush_o, tk || mr);
    chk("redirect_o", bus.redirect_o, tk || mr);
    if (tk || mr) chk("redirect_pc", bus.redirect_pc, tk ? 32'h100 + 32'(4 * s) : m_epc);
    @(posedge clk);
    hist.push_back(bus.irq_in);
    if (hist.size() > 4) void'(hist.pop_front());
    rise = hist[1] & ~hist[0];
    if (tk) begin
      m_pend[s] = 1'b0; m_epc = bus.ex_pc; m_cause = 4'(s); m_hand = 1'b1;
    end else if (mr) m_hand = 1'b0;
    m_pend |= rise;
    if (bus.en_we) m_mask = bus.en_wdata;
    #1;
    chk("in_handler", bus.in_handler, m_hand);
    chk("cause", bus.cause, m_cause);
    chk("epc", bus.epc, m_epc);
    chk("en_mask", bus.en_mask, m_mask);
    chk("pending", dut.pending_q, m_pend);
  endtask
  initial begin
    rst = 1'b1;
    bus.irq_in = 0; bus.en_we = 0; bus.en_wdata = 0; bus.ex_pc = 0;
    bus.ex_valid = 0; bus.pc_src = 0; bus.stall = 0; bus.mret_mem = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_handler", bus.in_handler, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_redirect", bus.redirect_o, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_epc", bus.epc, 0);
    chk("rst_mask", bus.en_mask, 0);
    rst = 1'b0;
    bus.en_we = 1; bus.en_wdata = 4'b0010;
    step();
    bus.en_we = 0; bus.irq_in = 4'b0010; bus.ex_valid = 1; bus.ex_pc = 32'h40;
    step();
    bus.irq_in = 0;
    step();
    step();
    #1;
    chk("t1_flush", bus.flush_o, 1);
    chk("t1_vec", bus.redirect_pc, 32'h104);
    step();
    chk("t1_epc", bus.epc, 32'h40);
    chk("t1_cause", bus.cause, 1);
    chk("t1_inh", bus.in_handler, 1);
    chk("t1_pend", dut.pending_q[1], 0);
    bus.irq_in = 4'b0010;
    repeat (4) step();
    chk("nest_inh", bus.in_handler, 1);
    chk("nest_pend", dut.pending_q[1], 1);
    bus.mret_mem = 1;
    #1;
    chk("mret_flush", bus.flush_o, 1);
    chk("mret_pc", bus.redirect_pc, 32'h40);
    step();
    bus.mret_mem = 0;
    chk("mret_inh", bus.in_handler, 0);
    step();
    chk("b2b_cause", bus.cause, 1);
    chk("b2b_inh", bus.in_handler, 1);
    bus.mret_mem = 1;
    step();
    bus.mret_mem = 0; bus.stall = 1; bus.irq_in = 0;
    step();
    bus.irq_in = 4'b0010;
    repeat (3) step();
    bus.irq_in = 0;
    step();
    bus.irq_in = 4'b0010;
    step();
    step();
    bus.stall = 0;
    step();
    chk("setwin_inh", bus.in_handler, 1);
    chk("setwin_pend", dut.pending_q[1], 1);
    bus.mret_mem = 1;
    step();
    bus.mret_mem = 0; bus.pc_src = 1;
    #1; chk("blk_pcsrc", bus.flush_o, 0);
    step();
    bus.pc_src = 0; bus.stall = 1;
    #1; chk("blk_stall", bus.flush_o, 0);
    step();
    bus.stall = 0; bus.ex_valid = 0;
    #1; chk("blk_valid", bus.flush_o, 0);
    step();
    bus.ex_valid = 1; bus.ex_pc = 32'h200;
    step();
    chk("blk_epc", bus.epc, 32'h200);
    bus.mret_mem = 1;
    step();
    bus.mret_mem = 0; bus.en_we = 1; bus.en_wdata = 4'b1110; bus.stall = 1; bus.irq_in = 0;
    step();
    bus.en_we = 0; bus.irq_in = 4'b1101;
    repeat (3) step();
    bus.stall = 0;
    #1; chk("prio_vec", bus.redirect_pc, 32'h108);
    step();
    chk("prio_cause", bus.cause, 2);
    chk("prio_pend0", dut.pending_q[0], 1);
    bus.mret_mem = 1;
    step();
    bus.mret_mem = 0;
    #1; chk("prio2_vec", bus.redirect_pc, 32'h10C);
    step();
    chk("prio2_cause", bus.cause, 3);
    #2; rst = 1'b1;
    #1;
    chk("arst_inh", bus.in_handler, 0);
    chk("arst_pend", dut.pending_q, 0);
    chk("arst_mask", bus.en_mask, 0);
    chk("arst_epc", bus.epc, 0);
    chk("arst_flush", bus.flush_o, 0);
    chk("arst_redirect", bus.redirect_o, 0);
    @(posedge clk);
    #1;
    chk("arst_flush2", bus.flush_o, 0);
    rst = 1'b0;
    m_reset();
    bus.irq_in = 0; bus.en_we = 1; bus.en_wdata = 4'($urandom);
    step();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) bus.irq_in ^= 4'(1 << $urandom_range(0, 3));
      bus.en_we    = ($urandom_range(0, 15) == 0);
      bus.en_wdata = 4'($urandom);
      bus.ex_pc    = $urandom & 32'hFFFF_FFFC;
      bus.ex_valid = ($urandom_range(0, 7) != 0);
      bus.pc_src   = ($urandom_range(0, 7) == 0);
      bus.stall    = ($urandom_range(0, 5) == 0);
      bus.mret_mem = ($urandom_range(0, 5) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
